// File: rtl/ea_sequencer_if.sv
// Handshake and byte-register bundle between the effective-address sequencer
// and the surrounding CPU datapath (operand memory, index registers, mux).
interface ea_sequencer_if;
    logic       start;
    logic [3:0] mode;
    logic [7:0] data_in;
    logic [7:0] x_reg;
    logic [7:0] y_reg;
    logic [2:0] address_select;
    logic       pc_inc;
    logic [7:0] dirl;
    logic [7:0] dirh;
    logic [7:0] indirl;
    logic [7:0] indirh;
    logic       busy;
    logic       done;
    logic       page_cross;

    modport master (
        output start, mode, data_in, x_reg, y_reg,
        input  address_select, pc_inc, dirl, dirh, indirl, indirh,
               busy, done, page_cross
    );

    modport slave (
        input  start, mode, data_in, x_reg, y_reg,
        output address_select, pc_inc, dirl, dirh, indirl, indirh,
               busy, done, page_cross
    );
endinterface

// File: rtl/ea_sequencer.sv
// 6502 effective-address sequencer: walks operand/pointer fetches and drives the address mux select.
// Build option: define PAGE_PENALTY_EN to spend an extra FIX cycle on indexed page crossings.
//
// state | meaning
// IDLE  | waiting for start, mux on PC
// OP1   | first operand byte from PC
// OP2   | second operand byte from PC
// PTRL  | pointer low byte read
// PTRH  | pointer high byte read
// FIX   | high-byte carry correction
// DONE  | effective address on the mux, done pulse
module ea_sequencer #(
    parameter logic [7:0] ZP_PAGE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    ea_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OP1  = 3'd1,
        S_OP2  = 3'd2,
        S_PTRL = 3'd3,
        S_PTRH = 3'd4,
        S_FIX  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        M_ZP   = 4'd0,
        M_ZPX  = 4'd1,
        M_ZPY  = 4'd2,
        M_ABS  = 4'd3,
        M_ABSX = 4'd4,
        M_ABSY = 4'd5,
        M_INDX = 4'd6,
        M_INDY = 4'd7,
        M_IND  = 4'd8
    } mode_t;

    localparam logic [2:0] SEL_PC      = 3'b000;
    localparam logic [2:0] SEL_ZP_DIR  = 3'b001;
    localparam logic [2:0] SEL_ABS_DIR = 3'b010;
    localparam logic [2:0] SEL_ZP_PTR  = 3'b011;
    localparam logic [2:0] SEL_ZP_PTR1 = 3'b100;
    localparam logic [2:0] SEL_IND     = 3'b101;
    localparam logic [2:0] SEL_IND1    = 3'b110;

    // The downstream mux hard-codes the zero page; the parameter only documents it.
    if (ZP_PAGE != 8'h00) begin : g_zp_page_ignored
    end

    state_t     state;
    state_t     state_nxt;
    mode_t      mode_q;
    logic [7:0] dirl_q;
    logic [7:0] dirh_q;
    logic [7:0] indirl_q;
    logic [7:0] indirh_q;
    logic       page_cross_q;

    logic       accept;
    logic       is_zp_mode;
    logic       is_abs_idx;
    logic [7:0] idx_op2;
    logic [8:0] sum_op2;
    logic [8:0] sum_ptr;
    logic       ptr_carry;

    assign accept     = bus.start && (bus.mode <= 4'd8);
    assign is_zp_mode = (mode_q == M_ZP) || (mode_q == M_ZPX) || (mode_q == M_ZPY);
    assign is_abs_idx = (mode_q == M_ABSX) || (mode_q == M_ABSY);
    assign idx_op2    = (mode_q == M_ABSY) ? bus.y_reg : bus.x_reg;
    assign sum_op2    = {1'b0, dirl_q} + {1'b0, idx_op2};
    assign sum_ptr    = {1'b0, bus.data_in} + {1'b0, bus.y_reg};
    // page_cross is cleared at start, so it doubles as the INDY low-add carry in PTRH
    assign ptr_carry  = (mode_q == M_INDY) && page_cross_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        bus.address_select = SEL_PC;
        bus.pc_inc         = 1'b0;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_OP1;
                end
            end
            S_OP1: begin
                bus.pc_inc = 1'b1;
                bus.busy   = 1'b1;
                case (mode_q)
                    M_ZP, M_ZPX, M_ZPY:         state_nxt = S_DONE;
                    M_ABS, M_ABSX, M_ABSY, M_IND: state_nxt = S_OP2;
                    M_INDX, M_INDY:             state_nxt = S_PTRL;
                    default:                    state_nxt = S_IDLE;
                endcase
            end
            S_OP2: begin
                bus.pc_inc = 1'b1;
                bus.busy   = 1'b1;
                if (mode_q == M_IND) begin
                    state_nxt = S_PTRL;
                end else begin
`ifdef PAGE_PENALTY_EN
                    state_nxt = (is_abs_idx && sum_op2[8]) ? S_FIX : S_DONE;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_PTRL: begin
                bus.busy           = 1'b1;
                bus.address_select = (mode_q == M_IND) ? SEL_IND : SEL_ZP_PTR;
                state_nxt          = S_PTRH;
            end
            S_PTRH: begin
                bus.busy           = 1'b1;
                bus.address_select = (mode_q == M_IND) ? SEL_IND1 : SEL_ZP_PTR1;
`ifdef PAGE_PENALTY_EN
                state_nxt          = ptr_carry ? S_FIX : S_DONE;
`else
                state_nxt          = S_DONE;
`endif
            end
            S_FIX: begin
                bus.busy           = 1'b1;
                bus.address_select = SEL_ABS_DIR;
                state_nxt          = S_DONE;
            end
            S_DONE: begin
                bus.done           = 1'b1;
                bus.address_select = is_zp_mode ? SEL_ZP_DIR : SEL_ABS_DIR;
                state_nxt          = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= M_ZP;
            dirl_q       <= 8'h00;
            dirh_q       <= 8'h00;
            indirl_q     <= 8'h00;
            indirh_q     <= 8'h00;
            page_cross_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_q       <= mode_t'(bus.mode);
                        page_cross_q <= 1'b0;
                    end
                end
                S_OP1: begin
                    case (mode_q)
                        M_ZP, M_ABS, M_ABSX, M_ABSY: dirl_q <= bus.data_in;
                        M_ZPX:  dirl_q   <= bus.data_in + bus.x_reg;
                        M_ZPY:  dirl_q   <= bus.data_in + bus.y_reg;
                        M_INDX: indirl_q <= bus.data_in + bus.x_reg;
                        M_INDY: indirl_q <= bus.data_in;
                        M_IND: begin
                            dirl_q   <= bus.data_in;
                            indirl_q <= bus.data_in;
                        end
                        default: ;
                    endcase
                end
                S_OP2: begin
                    case (mode_q)
                        M_ABS: dirh_q <= bus.data_in;
                        M_ABSX, M_ABSY: begin
                            dirl_q       <= sum_op2[7:0];
                            page_cross_q <= sum_op2[8];
`ifdef PAGE_PENALTY_EN
                            dirh_q       <= bus.data_in;
`else
                            dirh_q       <= bus.data_in + {7'd0, sum_op2[8]};
`endif
                        end
                        M_IND: indirh_q <= bus.data_in;
                        default: ;
                    endcase
                end
                S_PTRL: begin
                    if (mode_q == M_INDY) begin
                        dirl_q       <= sum_ptr[7:0];
                        page_cross_q <= sum_ptr[8];
                    end else begin
                        dirl_q <= bus.data_in;
                    end
                end
                S_PTRH: begin
`ifdef PAGE_PENALTY_EN
                    dirh_q <= bus.data_in;
`else
                    dirh_q <= bus.data_in + {7'd0, ptr_carry};
`endif
                end
                S_FIX: begin
                    dirh_q <= dirh_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.dirl       = dirl_q;
    assign bus.dirh       = dirh_q;
    assign bus.indirl     = indirl_q;
    assign bus.indirh     = indirh_q;
    assign bus.page_cross = page_cross_q;

endmodule

// File: tb/tb_ea_sequencer.sv
// Bench for ea_sequencer: directed addressing-mode cases, reset/protocol cases and random runs
// checked against an address-level model of each 6502 addressing mode.
module tb_ea_sequencer;

`ifdef PAGE_PENALTY_EN
    localparam bit PENALTY = 1'b1;
`else
    localparam bit PENALTY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ea_sequencer_if bus();

    ea_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] addr;

    always @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (bus.pc_inc) pc <= pc + 16'd1;
    end

    // Address mux the sequencer feeds; memory answers in the same cycle.
    always_comb begin
        addr = 16'h0000;
        case (bus.address_select)
            3'b000: addr = pc;
            3'b001: addr = {8'h00, bus.dirl};
            3'b010: addr = {bus.dirh, bus.dirl};
            3'b011: addr = {8'h00, bus.indirl};
            3'b100: addr = {8'h00, bus.indirl + 8'd1};
            3'b101: addr = {bus.indirh, bus.indirl};
            3'b110: addr = {bus.indirh, bus.indirl} + 16'd1;
            default: addr = 16'h0000;
        endcase
    end
    assign bus.data_in = mem[addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] push(input logic [23:0] seq, input logic [2:0] sel);
        return {seq[20:0], sel};
    endfunction

    task automatic run_one(input logic [3:0] m, input logic [7:0] xv, input logic [7:0] yv,
                           input logic [15:0] pcv, output logic [15:0] ea_obs, output int lat_obs);
        logic [7:0]  op1, op2, lo, hi, p, idx;
        logic [15:0] ea, ptr;
        logic        carry, chk_indl, chk_indh, busy_done, pcross_obs;
        logic [7:0]  exp_indl, exp_indh;
        logic [23:0] exp_seq, obs_seq;
        int          exp_lat, exp_incs, incs_obs;

        op1 = mem[pcv];
        op2 = mem[pcv + 16'd1];
        carry = 1'b0; chk_indl = 1'b0; chk_indh = 1'b0;
        exp_indl = 8'h00; exp_indh = 8'h00; ea = 16'h0000;
        exp_seq = 24'h7; exp_lat = 0; exp_incs = 0;
        case (m)
            4'd0, 4'd1, 4'd2: begin
                idx = (m == 4'd1) ? xv : ((m == 4'd2) ? yv : 8'h00);
                ea = {8'h00, op1 + idx};
                exp_seq = push(push(exp_seq, 3'b000), 3'b001);
                exp_lat = 2; exp_incs = 1;
            end
            4'd3, 4'd4, 4'd5: begin
                idx = (m == 4'd4) ? xv : ((m == 4'd5) ? yv : 8'h00);
                ea = {op2, op1} + {8'h00, idx};
                carry = (int'(op1) + int'(idx)) > 255;
                exp_seq = push(push(exp_seq, 3'b000), 3'b000);
                exp_lat = 2;
                if (PENALTY && carry) begin
                    exp_seq = push(exp_seq, 3'b010);
                    exp_lat++;
                end
                exp_seq = push(exp_seq, 3'b010);
                exp_lat++; exp_incs = 2;
            end
            4'd6, 4'd7: begin
                p = (m == 4'd6) ? op1 + xv : op1;
                lo = mem[{8'h00, p}];
                hi = mem[{8'h00, p + 8'd1}];
                ea = {hi, lo} + ((m == 4'd7) ? {8'h00, yv} : 16'h0000);
                carry = (m == 4'd7) && ((int'(lo) + int'(yv)) > 255);
                chk_indl = 1'b1; exp_indl = p;
                exp_seq = push(push(push(exp_seq, 3'b000), 3'b011), 3'b100);
                exp_lat = 3;
                if (PENALTY && carry) begin
                    exp_seq = push(exp_seq, 3'b010);
                    exp_lat++;
                end
                exp_seq = push(exp_seq, 3'b010);
                exp_lat++; exp_incs = 1;
            end
            default: begin
                ptr = {op2, op1};
                lo = mem[ptr];
                hi = mem[ptr + 16'd1];
                ea = {hi, lo};
                chk_indl = 1'b1; exp_indl = op1;
                chk_indh = 1'b1; exp_indh = op2;
                exp_seq = push(push(push(push(push(exp_seq, 3'b000), 3'b000), 3'b101), 3'b110), 3'b010);
                exp_lat = 5; exp_incs = 2;
            end
        endcase

        bus.x_reg = xv;
        bus.y_reg = yv;
        pc_load_val = pcv;
        pc_load = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        bus.mode = m;
        bus.start = 1'b1;
        obs_seq = 24'h7; incs_obs = 0; lat_obs = 0; ea_obs = 16'h0000;
        busy_done = 1'b1; pcross_obs = 1'bx;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            obs_seq = push(obs_seq, bus.address_select);
            if (bus.pc_inc) incs_obs++;
            if (bus.done) begin
                lat_obs = c;
                ea_obs = addr;
                busy_done = bus.busy;
                pcross_obs = bus.page_cross;
                break;
            end
        end
        check($sformatf("latency m%0d", m), lat_obs, exp_lat);
        check($sformatf("select_seq m%0d", m), obs_seq, exp_seq);
        check($sformatf("ea m%0d", m), ea_obs, ea);
        check($sformatf("pc_inc_count m%0d", m), incs_obs, exp_incs);
        check($sformatf("page_cross m%0d", m), pcross_obs, carry);
        check($sformatf("busy_at_done m%0d", m), busy_done, 1'b0);
        if (chk_indl) check($sformatf("indirl m%0d", m), bus.indirl, exp_indl);
        if (chk_indh) check($sformatf("indirh m%0d", m), bus.indirh, exp_indh);
        @(posedge clk); #1;
        check($sformatf("idle_after m%0d", m), {bus.done, bus.busy, bus.page_cross}, {2'b00, carry});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ea;
        int lat;
        logic any;

        bus.start = 1'b0; bus.mode = 4'd0; bus.x_reg = 8'h00; bus.y_reg = 8'h00;
        pc_load = 1'b1; pc_load_val = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.address_select, bus.pc_inc, bus.busy, bus.done, bus.page_cross,
               bus.dirl, bus.dirh, bus.indirl, bus.indirh}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem[16'h0400] = 8'hF8;
        run_one(4'd1, 8'h10, 8'h00, 16'h0400, ea, lat);
        check("plan_zpx_dirl", bus.dirl, 8'h08);
        check("plan_zpx_ea", ea, 16'h0008);

        mem[16'h0410] = 8'h34; mem[16'h0411] = 8'h12;
        run_one(4'd3, 8'h00, 8'h00, 16'h0410, ea, lat);
        check("plan_abs_ea", ea, 16'h1234);
        check("plan_abs_lat", lat, 3);

        mem[16'h0420] = 8'hF0; mem[16'h0421] = 8'h12;
        run_one(4'd5, 8'h00, 8'h20, 16'h0420, ea, lat);
        check("plan_absy_regs", {bus.dirh, bus.dirl, bus.page_cross}, {8'h13, 8'h10, 1'b1});
        check("plan_absy_lat", lat, PENALTY ? 4 : 3);

        mem[16'h0430] = 8'hFE; mem[16'h0003] = 8'h00; mem[16'h0004] = 8'h80;
        run_one(4'd6, 8'h05, 8'h00, 16'h0430, ea, lat);
        check("plan_indx_regs", {bus.indirl, bus.dirh, bus.dirl}, {8'h03, 16'h8000});
        check("plan_indx_lat", lat, 4);

        mem[16'h0440] = 8'hFF; mem[16'h0441] = 8'h02; mem[16'h02FF] = 8'hCD; mem[16'h0300] = 8'hAB;
        run_one(4'd8, 8'h00, 8'h00, 16'h0440, ea, lat);
        check("plan_ind_regs", {bus.dirh, bus.dirl}, 16'hABCD);
        check("plan_ind_lat", lat, 5);

        // Reset while INDY is reading its pointer low byte.
        bus.y_reg = 8'h44;
        pc_load_val = 16'h0450; pc_load = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        bus.mode = 4'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_sel", bus.address_select, 3'b011);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {bus.address_select, bus.pc_inc, bus.busy, bus.done, bus.page_cross,
               bus.dirl, bus.dirh, bus.indirl, bus.indirh}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        any = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            any = any | bus.done | bus.busy;
        end
        check("rst_no_done", any, 1'b0);

        bus.mode = 4'hC; bus.start = 1'b1;
        any = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            any = any | bus.done | bus.busy;
        end
        bus.start = 1'b0;
        check("bad_mode_ignored", any, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_one(4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom), 16'($urandom), ea, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ea_sequencer.md
Name: ea_sequencer

Overview:
- Effective-address sequencer, directly upstream of the CPU address multiplexer.
- Walks the operand and pointer fetch cycles for each 6502 addressing mode.
- Drives the mux's 3-bit address_select and the dirl/dirh/indirl/indirh byte registers. Applies X/Y indexing.
- Pulses done once the final effective address is presented on the mux.

Parameters:
- ZP_PAGE, 8'h00, reserved high byte for zero-page selects. Documentation only; the mux hard-codes 8'h00.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sequence; sampled only in IDLE
- mode  in  4  0 ZP, 1 ZPX, 2 ZPY, 3 ABS, 4 ABSX, 5 ABSY, 6 INDX, 7 INDY, 8 IND
- data_in  in  8  memory read data, valid in the same cycle its address is presented
- x_reg  in  8  X index
- y_reg  in  8  Y index
- address_select  out  3  mux select: 000 PC, 001 {00,dirl}, 010 {dirh,dirl}, 011 {00,indirl}, 100 {00,indirl+1}, 101 {indirh,indirl}, 110 {indirh,indirl}+1
- pc_inc  out  1  request PC increment at end of cycle (operand byte consumed)
- dirl, dirh, indirl, indirh  out  8 each  address byte registers
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse; final effective address on mux this cycle
- page_cross  out  1  indexed low-byte add carried; held until next start

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; all byte registers 0; address_select 000.
  - pc_inc, busy, done, page_cross all 0.
  - Reset mid-sequence aborts immediately; no done.
- States: IDLE, OP1, OP2, PTRL, PTRH, FIX, DONE. All outputs are registered or decoded from state only. No data_in-to-output combinational path except into registers.
- IDLE:
  - address_select 000.
  - start with mode 0-8: latch mode, clear page_cross, go to OP1.
  - mode 9-15: ignored, stay IDLE.
- OP1 (select 000, pc_inc 1):
  - ZP, ABS*, IND: dirl <= data_in.
  - ZPX: dirl <= data_in+x_reg. ZPY: dirl <= data_in+y_reg. Both wrap mod 256.
  - INDX: indirl <= data_in+x_reg, wrap mod 256.
  - INDY, IND: indirl <= data_in.
  - Next state: ZP/ZPX/ZPY -> DONE; ABS/ABSX/ABSY/IND -> OP2; INDX/INDY -> PTRL.
- OP2 (select 000, pc_inc 1):
  - ABS: dirh <= data_in.
  - ABSX/ABSY: {c,dirl} <= dirl+idx; dirh <= data_in; page_cross <= c.
  - IND: indirh <= data_in; indirl unchanged. Because IND copies dirl to indirl, both hold the low operand.
  - Next state: IND -> PTRL; others -> FIX if required, else DONE.
- PTRL:
  - Select 011 for INDX/INDY, 101 for IND.
  - INDY: {c,dirl} <= data_in+y_reg; page_cross <= c.
  - INDX/IND: dirl <= data_in.
  - Next state: PTRH.
- PTRH:
  - Select 100 for INDX/INDY, 110 for IND.
  - The pointer high read never wraps within the page for IND; 16-bit +1 applies.
  - dirh <= data_in.
  - Next state: FIX if required, else DONE.
- FIX (select 010): dirh <= dirh+1 (wrap mod 256). Next state: DONE.
- DONE:
  - Select 001 for ZP/ZPX/ZPY, 010 otherwise.
  - done 1, busy 0; next state IDLE.
  - A start in DONE is ignored; start is accepted only in IDLE.
- busy is 1 in OP1..FIX.
- Latency, start-cycle to done (no FIX): ZP* 2; ABS* 3; INDX/INDY 4; IND 5.

Optional Feature:
- PAGE_PENALTY_EN defined:
  - Carry from the ABSX/ABSY/INDY low add sets page_cross and inserts the FIX state: one extra cycle, dirh incremented there.
- PAGE_PENALTY_EN undefined:
  - FIX is never entered; carry is added into dirh in the same state (OP2 or PTRH).
  - page_cross is still reported.
  - Latency is fixed per mode.

Test Plan:
- ZPX, x_reg=8'h10, OP1 data 8'hF8:
  - required: dirl=8'h08; done 2 cycles after start with select 001.
  - required: pc_inc high exactly 1 cycle; page_cross 0.
- ABS, data 8'h34 then 8'h12:
  - required: {dirh,dirl}=16'h1234; select 010 at done; done at cycle 3; pc_inc 2 cycles.
- ABSY, y_reg=8'h20, data 8'hF0, 8'h12:
  - macro on: dirl=8'h10, dirh=8'h13, page_cross 1, done at cycle 4 via FIX.
  - macro off: same values, done at cycle 3.
- INDX, x_reg=8'h05, OP1 data 8'hFE; mem[0x0003]=8'h00, mem[0x0004]=8'h80:
  - required: indirl=8'h03; selects 011 then 100; {dirh,dirl}=16'h8000; done at 4.
- IND, operands 8'hFF,8'h02; mem[0x02FF]=8'hCD, mem[0x0300]=8'hAB:
  - required: selects 101 then 110; {dirh,dirl}=16'hABCD; done at 5.
- Reset and protocol checks:
  - rst_n low during PTRL of INDY: all outputs 0 and state IDLE immediately; no done pulse after release.
  - mode 4'hC with start: no busy, no done.
